// File: rtl/apple_spawner.sv
// Apple owner for the snake game: holds the apple position, detects the
// head eating it, keeps the score, and picks a new grid-aligned position
// from a free-running LFSR. The position is handed to the draw FSM with a
// req/ack handshake.
module apple_spawner #(
    parameter int          XSCREEN  = 160,
    parameter int          YSCREEN  = 120,
    parameter int          CELL     = 10,
    parameter int          COLW     = 4,
    parameter int          ROWW     = 4,
    parameter int          APPLE_X0 = 80,
    parameter int          APPLE_Y0 = 60,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    input  logic       head_valid,
    input  logic       apple_ack,
    output logic [7:0] apple_x,
    output logic [6:0] apple_y,
    output logic       apple_req,
    output logic       eat,
    output logic [7:0] score
);

    // A zero seed would lock the LFSR at zero forever, so it is replaced.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          NCOL      = XSCREEN / CELL;
    localparam int          NROW      = YSCREEN / CELL;
    localparam logic [8:0]  CELL9     = 9'(CELL);
    localparam logic [7:0]  CELL8     = 8'(CELL);

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        REQ
    } state_t;

    state_t      state_q,   state_d;
    logic [15:0] lfsr_q,    lfsr_d;
    logic [7:0]  apple_x_q, apple_x_d;
    logic [6:0]  apple_y_q, apple_y_d;
    logic        apple_req_q, apple_req_d;
    logic        eat_q,     eat_d;
    logic [7:0]  score_q,   score_d;
    logic [7:0]  head_lx_q, head_lx_d;
    logic [6:0]  head_ly_q, head_ly_d;

    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [7:0]      cand_x;
    logic [6:0]      cand_y;
    logic            cand_ok;

    // Box overlap: both axis distances strictly below one cell. The
    // differences are taken signed at 9 bits so they never wrap.
    function automatic logic boxes_hit(input logic [7:0] ax, input logic [6:0] ay,
                                       input logic [7:0] bx, input logic [6:0] by);
        logic signed [8:0] dx;
        logic signed [8:0] dy;
        logic [8:0]        adx;
        logic [8:0]        ady;
        dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy  = $signed({2'b0, ay}) - $signed({2'b0, by});
        adx = dx[8] ? 9'(-dx) : 9'(dx);
        ady = dy[8] ? 9'(-dy) : 9'(dy);
        return (adx < CELL9) && (ady < CELL9);
    endfunction

    // Candidate apple position from the low LFSR bits, scaled to pixels.
    always_comb begin
        col     = lfsr_q[COLW-1:0];
        row     = lfsr_q[COLW+ROWW-1:COLW];
        cand_x  = 8'(9'(col) * CELL9);
        cand_y  = 7'(8'(row) * CELL8);
        cand_ok = (32'(col) < NCOL) && (32'(row) < NROW) &&
                  !boxes_hit(head_lx_q, head_ly_q, cand_x, cand_y);
    end

    // Next-state logic for the FSM, LFSR, score and head latch.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        apple_x_d = apple_x_q;
        apple_y_d = apple_y_q;
        eat_d     = 1'b0;
        score_d   = score_q;
        head_lx_d = head_lx_q;
        head_ly_d = head_ly_q;
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        if (head_valid) begin
            head_lx_d = head_x;
            head_ly_d = head_y;
        end

        case (state_q)
            IDLE: begin
                if (head_valid && boxes_hit(head_x, head_y, apple_x_q, apple_y_q)) begin
                    eat_d   = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    state_d = PICK;
                end
            end
            PICK: begin
                if (cand_ok) begin
                    apple_x_d = cand_x;
                    apple_y_d = cand_y;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (apple_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        apple_req_d = (state_d == REQ);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Resetn) begin
            state_q     <= REQ;
            lfsr_q      <= LFSR_INIT;
            apple_x_q   <= 8'(APPLE_X0);
            apple_y_q   <= 7'(APPLE_Y0);
            apple_req_q <= 1'b1;
            eat_q       <= 1'b0;
            score_q     <= 8'd0;
            head_lx_q   <= 8'd0;
            head_ly_q   <= 7'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            apple_x_q   <= apple_x_d;
            apple_y_q   <= apple_y_d;
            apple_req_q <= apple_req_d;
            eat_q       <= eat_d;
            score_q     <= score_d;
            head_lx_q   <= head_lx_d;
            head_ly_q   <= head_ly_d;
        end
    end

    assign apple_x   = apple_x_q;
    assign apple_y   = apple_y_q;
    assign apple_req = apple_req_q;
    assign eat       = eat_q;
    assign score     = score_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset values, handshake, eat/score,
// candidate selection against an LFSR reference, reset in PICK, score
// saturation and the zero-seed replacement.
module tb_apple_spawner;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic [7:0] head_x   = 8'd0;
    logic [6:0] head_y   = 7'd0;
    logic       head_valid = 1'b0;
    logic       apple_ack  = 1'b0;

    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic       apple_req;
    logic       eat;
    logic [7:0] score;

    logic [7:0] z_apple_x;
    logic [6:0] z_apple_y;
    logic       z_apple_req;
    logic       z_eat;
    logic [7:0] z_score;

    apple_spawner dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .head_x    (head_x),
        .head_y    (head_y),
        .head_valid(head_valid),
        .apple_ack (apple_ack),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .apple_req (apple_req),
        .eat       (eat),
        .score     (score)
    );

    apple_spawner #(.SEED(16'h0000)) dut0 (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .head_x    (head_x),
        .head_y    (head_y),
        .head_valid(head_valid),
        .apple_ack (apple_ack),
        .apple_x   (z_apple_x),
        .apple_y   (z_apple_y),
        .apple_req (z_apple_req),
        .eat       (z_eat),
        .score     (z_score)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference LFSR: 16-bit Galois, taps 0xB400, reset value 0xACE1.
    logic [15:0] m;
    logic        m_valid = 1'b0;
    int          lfsr_bad = 0;
    int          z_out_bad = 0;

    always @(posedge CLOCK_50) begin
        if (!Resetn) begin
            m       <= 16'hACE1;
            m_valid <= 1'b1;
        end else begin
            m <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
        end
    end

    always @(negedge CLOCK_50) begin
        if (m_valid) begin
            if (dut.lfsr_q !== m || dut0.lfsr_q !== m || dut.lfsr_q == 16'h0000)
                lfsr_bad++;
            if (z_apple_x !== apple_x || z_apple_y !== apple_y || z_apple_req !== apple_req ||
                z_eat !== eat || z_score !== score)
                z_out_bad++;
        end
    end

    int exp_score = 0;
    int lx = 0;
    int ly = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit tb_hit(input int ax, input int ay, input int bx, input int by);
        int dx;
        int dy;
        dx = ax - bx;
        dy = ay - by;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx < 10) && (dy < 10);
    endfunction

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    // Drive one eating head step, then follow PICK with the reference LFSR
    // to predict exactly which candidate is accepted, then acknowledge.
    task automatic do_eat(input int hx, input int hy);
        int  ex;
        int  ey;
        bit  found;
        int  c;
        int  r;
        head_x     = 8'(hx);
        head_y     = 7'(hy);
        head_valid = 1'b1;
        tick();
        head_valid = 1'b0;
        lx = hx;
        ly = hy;
        exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        check("eat_rise", {31'd0, eat}, 32'd1);
        check("score", {24'd0, score}, exp_score);
        check("req_low_in_pick", {31'd0, apple_req}, 32'd0);
        ex = 0;
        ey = 0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            c = int'(m[3:0]);
            r = int'(m[7:4]);
            if (r < 12 && !tb_hit(lx, ly, c * 10, r * 10)) begin
                ex = c * 10;
                ey = r * 10;
                found = 1'b1;
            end
            tick();
        end
        check("pick_bound", {31'd0, found}, 32'd1);
        check("eat_one_cycle", {31'd0, eat}, 32'd0);
        check("req_rise", {31'd0, apple_req}, 32'd1);
        check("new_x", {24'd0, apple_x}, ex);
        check("new_y", {25'd0, apple_y}, ey);
        check("x_on_grid", {31'd0, (apple_x % 10 == 0) && (apple_x < 160)}, 32'd1);
        check("y_on_grid", {31'd0, (apple_y % 10 == 0) && (apple_y < 120)}, 32'd1);
        check("no_overlap", {31'd0, tb_hit(lx, ly, int'(apple_x), int'(apple_y))}, 32'd0);
        apple_ack = 1'b1;
        tick();
        apple_ack = 1'b0;
        check("ack_req_low", {31'd0, apple_req}, 32'd0);
    endtask

    initial begin
        int hold_bad;

        // Reset for two cycles, then hold with no ack.
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        check("rst_x", {24'd0, apple_x}, 32'd80);
        check("rst_y", {25'd0, apple_y}, 32'd60);
        check("rst_req", {31'd0, apple_req}, 32'd1);
        check("rst_score", {24'd0, score}, 32'd0);
        check("rst_eat", {31'd0, eat}, 32'd0);
        hold_bad = 0;
        repeat (20) begin
            tick();
            if (apple_x !== 8'd80 || apple_y !== 7'd60 || apple_req !== 1'b1 ||
                score !== 8'd0 || eat !== 1'b0)
                hold_bad++;
        end
        check("hold_20", hold_bad, 32'd0);

        // Ack, then a head exactly one cell away: no overlap.
        apple_ack = 1'b1;
        tick();
        apple_ack = 1'b0;
        check("ack_req_low", {31'd0, apple_req}, 32'd0);
        head_x = 8'd70;
        head_y = 7'd60;
        head_valid = 1'b1;
        tick();
        head_valid = 1'b0;
        check("edge_no_eat", {31'd0, eat}, 32'd0);
        check("edge_score", {24'd0, score}, 32'd0);
        tick();
        check("edge_req_low", {31'd0, apple_req}, 32'd0);

        // Overlapping head eats; a new apple is chosen.
        do_eat(75, 55);

        // Ack outside REQ is ignored.
        apple_ack = 1'b1;
        tick();
        apple_ack = 1'b0;
        check("stray_ack_req", {31'd0, apple_req}, 32'd0);

        // Reset while in PICK.
        head_x = apple_x;
        head_y = apple_y;
        head_valid = 1'b1;
        tick();
        head_valid = 1'b0;
        check("pick_eat", {31'd0, eat}, 32'd1);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        check("pickrst_x", {24'd0, apple_x}, 32'd80);
        check("pickrst_y", {25'd0, apple_y}, 32'd60);
        check("pickrst_req", {31'd0, apple_req}, 32'd1);
        check("pickrst_score", {24'd0, score}, 32'd0);
        check("pickrst_eat", {31'd0, eat}, 32'd0);
        tick();
        check("pickrst_no_stale_eat", {31'd0, eat}, 32'd0);
        check("pickrst_req_hold", {31'd0, apple_req}, 32'd1);
        exp_score = 0;
        apple_ack = 1'b1;
        tick();
        apple_ack = 1'b0;
        check("pickrst_ack", {31'd0, apple_req}, 32'd0);

        // Many eats: score saturates at 255.
        for (int i = 0; i < 300; i++) begin
            do_eat(int'(apple_x), int'(apple_y));
        end
        check("score_sat", {24'd0, score}, 32'd255);

        // Long idle run covering a full LFSR period.
        repeat (70000) tick();
        check("lfsr_ref", lfsr_bad, 32'd0);
        check("seed0_outputs", z_out_bad, 32'd0);
        check("final_score", {24'd0, score}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
